sr_cmd_debouncer: RTL and testbench



---
 rtl/sr_cmd_debouncer.sv | 229 ++++++++++++++++++++++
 tb/tb_sr_cmd_debouncer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_debouncer.sv
// sr_cmd_debouncer: sync + debounce + edge detect of set/reset/clear buttons,
// sequencing S/R/En/clear latch commands. Optional macro: SR_CMD_PENDING_EN.
module sr_cmd_debouncer #(
  parameter int DB_CYCLES = 8,
  parameter int EN_CYCLES = 2,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic reset_btn,
  input  logic clr_btn,
  output logic S,
  output logic R,
  output logic En,
  output logic clear,
  output logic busy,
  output logic conflict
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_DRIVE   = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_CLR     = 3'd4;

  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_MAX = CNT_W'(EN_CYCLES - 1);

  // bit 0 = set, bit 1 = reset, bit 2 = clear
  logic [2:0] w_raw;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] r_level;
  logic [2:0] r_level_d;
  logic [2:0][CNT_W-1:0] r_dbcnt;
  logic [2:0] w_press;

  logic w_set_p;
  logic w_rst_p;
  logic w_clr_p;
  logic w_conf;
  logic w_cmd_req;

  logic [2:0]       r_state;
  logic [2:0]       w_state_n;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_n;
  logic             r_cmd;
  logic             w_cmd_n;
  logic             w_act_n;

`ifdef SR_CMD_PENDING_EN
  logic r_pend_v;
  logic r_pend_set;
  logic w_pend_v_n;
  logic w_pend_set_n;
`endif

  logic r_S;
  logic r_R;
  logic r_En;
  logic r_clear;
  logic r_conf;

  assign w_raw = {clr_btn, reset_btn, set_btn};

  // two-flop synchroniser for the raw buttons
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // per-button debouncer: level flips after DB_CYCLES differing samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_level <= '0;
      r_dbcnt <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_dbcnt[i] <= '0;
        end else if (r_dbcnt[i] == DB_MAX) begin
          r_level[i] <= ~r_level[i];
          r_dbcnt[i] <= '0;
        end else begin
          r_dbcnt[i] <= r_dbcnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // delayed debounced level for rising-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_level_d <= '0;
    end else begin
      r_level_d <= r_level;
    end
  end

  assign w_press   = r_level & ~r_level_d;
  assign w_set_p   = w_press[0];
  assign w_rst_p   = w_press[1];
  assign w_clr_p   = w_press[2];
  assign w_conf    = w_set_p & w_rst_p;
  assign w_cmd_req = w_set_p ^ w_rst_p;

  // next-state logic; clear press overrides everything
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_cmd_n   = r_cmd;
`ifdef SR_CMD_PENDING_EN
    w_pend_v_n   = r_pend_v;
    w_pend_set_n = r_pend_set;
`endif
    if (w_clr_p) begin
      w_state_n = ST_CLR;
      w_cnt_n   = '0;
`ifdef SR_CMD_PENDING_EN
      w_pend_v_n = 1'b0;
`endif
    end else begin
`ifdef SR_CMD_PENDING_EN
      if (w_cmd_req && r_state != ST_IDLE && r_state != ST_CLR) begin
        w_pend_v_n   = 1'b1;
        w_pend_set_n = w_set_p;
      end
`endif
      unique case (r_state)
        ST_IDLE: begin
          if (w_cmd_req) begin
            w_state_n = ST_SETUP;
            w_cmd_n   = w_set_p;
          end
        end
        ST_SETUP: begin
          w_state_n = ST_DRIVE;
          w_cnt_n   = '0;
        end
        ST_DRIVE: begin
          if (r_cnt == EN_MAX) begin
            w_state_n = ST_RELEASE;
          end else begin
            w_cnt_n = r_cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          w_state_n = ST_IDLE;
`ifdef SR_CMD_PENDING_EN
          if (w_cmd_req) begin
            w_state_n  = ST_SETUP;
            w_cmd_n    = w_set_p;
            w_pend_v_n = 1'b0;
          end else if (r_pend_v) begin
            w_state_n  = ST_SETUP;
            w_cmd_n    = r_pend_set;
            w_pend_v_n = 1'b0;
          end
`endif
        end
        ST_CLR: begin
          if (r_cnt == EN_MAX) begin
            w_state_n = ST_IDLE;
          end else begin
            w_cnt_n = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_n = ST_IDLE;
        end
      endcase
    end
  end

  assign w_act_n = (w_state_n == ST_SETUP) ||
                   (w_state_n == ST_DRIVE) ||
                   (w_state_n == ST_RELEASE);

  // FSM state and outputs registered from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cmd   <= 1'b0;
      r_S     <= 1'b0;
      r_R     <= 1'b0;
      r_En    <= 1'b0;
      r_clear <= 1'b0;
      r_conf  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_cmd   <= w_cmd_n;
      r_S     <= w_act_n & w_cmd_n;
      r_R     <= w_act_n & ~w_cmd_n;
      r_En    <= (w_state_n == ST_DRIVE);
      r_clear <= (w_state_n == ST_CLR);
      r_conf  <= w_conf;
    end
  end

`ifdef SR_CMD_PENDING_EN
  // one-deep pending command slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend_v   <= 1'b0;
      r_pend_set <= 1'b0;
    end else begin
      r_pend_v   <= w_pend_v_n;
      r_pend_set <= w_pend_set_n;
    end
  end
`endif

  assign S        = r_S;
  assign R        = r_R;
  assign En       = r_En;
  assign clear    = r_clear;
  assign conflict = r_conf;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// tb_sr_cmd_debouncer: vector table plus hand sequences for sr_cmd_debouncer.
// Expectations follow SR_CMD_PENDING_EN when it is defined.
module tb_sr_cmd_debouncer;

  logic clk = 1'b0;
  logic rst_n;
  logic set_btn;
  logic reset_btn;
  logic clr_btn;
  logic S, R, En, clear, busy, conflict;

  int checks = 0;
  int errors = 0;

  // expected bits: {S, R, En, clear, busy, conflict}
  localparam logic [5:0] E0    = 6'b000000;
  localparam logic [5:0] SSET  = 6'b100010;
  localparam logic [5:0] DSET  = 6'b101010;
  localparam logic [5:0] SRST  = 6'b010010;
  localparam logic [5:0] DRST  = 6'b011010;
  localparam logic [5:0] CLRP  = 6'b000110;
  localparam logic [5:0] CONF  = 6'b000001;

  typedef struct {
    logic       rstn;
    logic       s;
    logic       r;
    logic       c;
    logic [5:0] exp;
    string      tag;
  } vec_t;

  vec_t q[$];

  always #5 clk = ~clk;

  sr_cmd_debouncer #(
    .DB_CYCLES(8),
    .EN_CYCLES(2),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .set_btn(set_btn),
    .reset_btn(reset_btn),
    .clr_btn(clr_btn),
    .S(S),
    .R(R),
    .En(En),
    .clear(clear),
    .busy(busy),
    .conflict(conflict)
  );

  task automatic add(input logic rn, input logic s, input logic r,
                     input logic c, input logic [5:0] e,
                     input string t, input int n);
    vec_t v;
    v.rstn = rn;
    v.s    = s;
    v.r    = r;
    v.c    = c;
    v.exp  = e;
    v.tag  = t;
    repeat (n) q.push_back(v);
  endtask

  task automatic chk(input string t, input logic [5:0] got,
                     input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", t, got, exp);
    end
  endtask

  task automatic inv_chk();
    checks++;
    if ((S & R) | (clear & En)) begin
      errors++;
      $display("FAIL invariant: S=%b R=%b En=%b clear=%b", S, R, En, clear);
    end
  endtask

  int first_s;
  int s_rises;
  logic s_prev;

  initial begin
    rst_n = 1'b0;
    set_btn = 1'b0;
    reset_btn = 1'b0;
    clr_btn = 1'b0;

    // reset state
    add(0, 0, 0, 0, E0, "reset", 3);
    add(1, 0, 0, 0, E0, "idle", 3);

    // clean set
    add(1, 1, 0, 0, E0,   "set_wait", 10);
    add(1, 1, 0, 0, SSET, "set_setup", 1);
    add(1, 1, 0, 0, DSET, "set_drive", 2);
    add(1, 1, 0, 0, SSET, "set_release", 1);
    add(1, 1, 0, 0, E0,   "set_done", 1);
    add(1, 0, 0, 0, E0,   "set_up", 14);

    // bounce rejection then held reset
    add(1, 0, 1, 0, E0,   "bounce_h3", 3);
    add(1, 0, 0, 0, E0,   "bounce_l", 3);
    add(1, 0, 1, 0, E0,   "bounce_h5", 5);
    add(1, 0, 0, 0, E0,   "bounce_l", 3);
    add(1, 0, 1, 0, E0,   "bounce_h7", 7);
    add(1, 0, 0, 0, E0,   "bounce_l", 3);
    add(1, 0, 1, 0, E0,   "rst_wait", 10);
    add(1, 0, 1, 0, SRST, "rst_setup", 1);
    add(1, 0, 1, 0, DRST, "rst_drive", 2);
    add(1, 0, 1, 0, SRST, "rst_release", 1);
    add(1, 0, 1, 0, E0,   "rst_done", 1);
    add(1, 0, 0, 0, E0,   "rst_up", 14);

    // set/reset conflict
    add(1, 1, 1, 0, E0,   "conf_wait", 10);
    add(1, 1, 1, 0, CONF, "conf_pulse", 1);
    add(1, 1, 1, 0, E0,   "conf_after", 4);
    add(1, 0, 0, 0, E0,   "conf_up", 14);

    // clear abort during DRIVE
    add(1, 1, 0, 0, E0,   "abort_wait", 2);
    add(1, 1, 0, 1, E0,   "abort_wait", 8);
    add(1, 1, 0, 1, SSET, "abort_setup", 1);
    add(1, 1, 0, 1, DSET, "abort_drive", 1);
    add(1, 1, 0, 1, CLRP, "abort_clear", 2);
    add(1, 1, 0, 1, E0,   "abort_idle", 1);
    add(1, 0, 0, 0, E0,   "abort_up", 14);

    // reset press during DRIVE of a set command
    add(1, 1, 0, 0, E0,   "pend_wait", 2);
    add(1, 1, 1, 0, E0,   "pend_wait", 8);
    add(1, 1, 1, 0, SSET, "pend_setup", 1);
    add(1, 1, 1, 0, DSET, "pend_drive", 2);
    add(1, 1, 1, 0, SSET, "pend_release", 1);
`ifdef SR_CMD_PENDING_EN
    add(1, 1, 1, 0, SRST, "pend_r_setup", 1);
    add(1, 1, 1, 0, DRST, "pend_r_drive", 2);
    add(1, 1, 1, 0, SRST, "pend_r_release", 1);
    add(1, 1, 1, 0, E0,   "pend_done", 1);
`else
    add(1, 1, 1, 0, E0,   "pend_dropped", 5);
`endif
    add(1, 0, 0, 0, E0,   "pend_up", 14);

    // reset mid-command
    add(1, 1, 0, 0, E0,   "mid_wait", 10);
    add(1, 1, 0, 0, SSET, "mid_setup", 1);
    add(1, 1, 0, 0, DSET, "mid_drive", 1);
    add(0, 0, 0, 0, E0,   "mid_reset", 2);
    add(1, 0, 0, 0, E0,   "mid_after", 20);

    foreach (q[k]) begin
      @(negedge clk);
      rst_n     = q[k].rstn;
      set_btn   = q[k].s;
      reset_btn = q[k].r;
      clr_btn   = q[k].c;
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d]", q[k].tag, k),
          {S, R, En, clear, busy, conflict}, q[k].exp);
      inv_chk();
    end

    // button held while reset deasserts: one command, S after edge 10
    @(negedge clk);
    rst_n = 1'b0;
    set_btn = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    first_s = -1;
    s_rises = 0;
    s_prev = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (S && !s_prev) begin
        s_rises++;
        if (first_s < 0) first_s = k;
      end
      s_prev = S;
    end
    checks++;
    if (first_s != 10) begin
      errors++;
      $display("FAIL held_reset_latency: got %0d expected 10", first_s);
    end
    checks++;
    if (s_rises != 1) begin
      errors++;
      $display("FAIL held_reset_count: got %0d expected 1", s_rises);
    end
    @(negedge clk);
    set_btn = 1'b0;
    repeat (14) @(negedge clk);
    chk("held_reset_idle", {S, R, En, clear, busy, conflict}, E0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
